tag_decoder: RTL and testbench

TAG_DECODER -- requirements
Module: tag_decoder

---
 rtl/tag_decoder.sv | 99 +++++++++
 tb/tb_tag_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/tag_decoder.sv
// Binary-tag to one-hot decoder behind a 2-entry skid buffer with valid/ready on both sides.
// Optional accepted-tag counter on out_count is enabled by defining TAG_DECODER_STATS_EN.
module tag_decoder #(
  parameter int BIT_WIDTH = 8,
  localparam int TAG_W = $clog2(BIT_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [TAG_W-1:0]     in_tag,
  input  logic                 in_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BIT_WIDTH-1:0] out_onehot,
  output logic [TAG_W-1:0]     out_tag,
  output logic [15:0]          out_count
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

  typedef struct packed {
    logic [BIT_WIDTH-1:0] onehot;
    logic [TAG_W-1:0]     tag;
  } entry_t;

  state_e state_q;
  entry_t main_q, skid_q;
  entry_t in_ent;
  logic   acc, drn;

  // Decode at the input so both buffer slots hold ready-to-drive vectors.
  for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_dec
    assign in_ent.onehot[i] = in_en && (in_tag == TAG_W'(i));
  end
  assign in_ent.tag = in_tag;

  assign in_ready   = !rst && (state_q != TWO);
  assign out_valid  = (state_q != EMPTY);
  assign out_onehot = main_q.onehot;
  assign out_tag    = main_q.tag;

  assign acc = in_valid && in_ready;
  assign drn = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            main_q  <= in_ent;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (acc && drn) begin
            main_q  <= in_ent;
          end else if (acc) begin
            skid_q  <= in_ent;
            state_q <= TWO;
          end else if (drn) begin
            state_q <= EMPTY;
          end
        end
        TWO: begin
          // in_ready is low here, so only a drain can happen; skid moves up to keep FIFO order.
          if (drn) begin
            main_q  <= skid_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

`ifdef TAG_DECODER_STATS_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (acc && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign out_count = cnt_q;
`else
  assign out_count = '0;
`endif

endmodule

// File: tb/tb_tag_decoder.sv
// Randomized bench for tag_decoder, checked against a queue-based model of a 2-deep FIFO.
module tb_tag_decoder;
  localparam int BW = 8;
  localparam int TW = $clog2(BW);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_en, out_valid, out_ready;
  logic [TW-1:0] in_tag, out_tag;
  logic [BW-1:0] out_onehot;
  logic [15:0]   out_count;

  tag_decoder #(.BIT_WIDTH(BW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_en(in_en),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_onehot(out_onehot), .out_tag(out_tag), .out_count(out_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] tag;
    bit            en;
  } ent_t;

  ent_t        mq[$];
  int unsigned mcnt;
  int          compared = 0;
  int          mismatched = 0;

  function automatic logic [BW-1:0] exp_oh(ent_t x);
    logic [BW-1:0] one;
    one = 1;
    return x.en ? (one << x.tag) : '0;
  endfunction

  function automatic logic [15:0] exp_cnt();
`ifdef TAG_DECODER_STATS_EN
    return 16'(mcnt);
`else
    return 16'h0000;
`endif
  endfunction

  // Drive one cycle from a negedge, advance the model at the posedge, return at the next negedge.
  task automatic step(input logic v, input logic [TW-1:0] t, input logic e, input logic r);
    bit   acc, drn;
    ent_t x;
    in_valid = v; in_tag = t; in_en = e; out_ready = r;
    acc = v && (mq.size() < 2);
    drn = (mq.size() > 0) && r;
    @(posedge clk);
    if (drn) mq.delete(0);
    if (acc) begin
      x.tag = t; x.en = e;
      mq.push_back(x);
      if (mcnt < 65535) mcnt++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 0; in_tag = '0; in_en = 0; out_ready = 0;
    mq.delete(); mcnt = 0;
    #1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    compared++; if (out_onehot !== '0) begin mismatched++; $display("FAIL rst_onehot got %h want 0", out_onehot); end
    compared++; if (out_tag !== '0) begin mismatched++; $display("FAIL rst_tag got %0d want 0", out_tag); end
    compared++; if (out_count !== 16'h0) begin mismatched++; $display("FAIL rst_count got %h want 0", out_count); end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL rel_out_valid got %b want 0", out_valid); end
    @(negedge clk);
  endtask

  task automatic test_basic();
    step(1, 3'd5, 1, 1);
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL t5_valid got %b want 1", out_valid); end
    compared++; if (out_onehot !== 8'b0010_0000) begin mismatched++; $display("FAIL t5_onehot got %h want 20", out_onehot); end
    compared++; if (out_tag !== 3'd5) begin mismatched++; $display("FAIL t5_tag got %0d want 5", out_tag); end
    step(1, 3'd3, 0, 1);
    compared++; if (out_valid !== 1'b1) begin mismatched++; $display("FAIL t3_valid got %b want 1", out_valid); end
    compared++; if (out_onehot !== 8'h00) begin mismatched++; $display("FAIL t3_onehot got %h want 00", out_onehot); end
    compared++; if (out_tag !== 3'd3) begin mismatched++; $display("FAIL t3_tag got %0d want 3", out_tag); end
    step(0, 3'd7, 1, 1);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL drain_valid got %b want 0", out_valid); end
  endtask

  task automatic test_skid();
    step(1, 3'd1, 1, 0);
    step(1, 3'd2, 1, 0);
    for (int k = 0; k < 3; k++) begin
      compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL skid_in_ready got %b want 0", in_ready); end
      compared++; if (out_onehot !== 8'h02) begin mismatched++; $display("FAIL skid_hold got %h want 02", out_onehot); end
      step(1, 3'(k + 4), 1, 0);
    end
    step(0, 3'd0, 0, 1);
    compared++; if (out_onehot !== 8'h04 || out_valid !== 1'b1) begin mismatched++; $display("FAIL skid_second got %h/%b want 04/1", out_onehot, out_valid); end
    compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL skid_ready_back got %b want 1", in_ready); end
    step(0, 3'd0, 0, 1);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL skid_empty got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] want;
    for (int k = 0; k < BW; k++) begin
      step(1, TW'(k), 1, 1);
      want = '0; want[k] = 1'b1;
      compared++; if (out_valid !== 1'b1 || out_onehot !== want || out_tag !== TW'(k)) begin
        mismatched++; $display("FAIL b2b_%0d got %b/%h/%0d want 1/%h/%0d", k, out_valid, out_onehot, out_tag, want, k);
      end
      compared++; if (in_ready !== 1'b1) begin mismatched++; $display("FAIL b2b_ready_%0d got %b want 1", k, in_ready); end
    end
    step(0, 3'd0, 0, 1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 3000; k++) begin
      step(($urandom_range(0, 3) != 0), TW'($urandom), 1'($urandom), ($urandom_range(0, 2) != 0));
      compared++; if (out_valid !== (mq.size() > 0)) begin mismatched++; $display("FAIL rnd_valid cyc %0d got %b want %b", k, out_valid, mq.size() > 0); end
      compared++; if (in_ready !== (mq.size() < 2)) begin mismatched++; $display("FAIL rnd_ready cyc %0d got %b want %b", k, in_ready, mq.size() < 2); end
      if (mq.size() > 0) begin
        compared++; if (out_onehot !== exp_oh(mq[0])) begin mismatched++; $display("FAIL rnd_onehot cyc %0d got %h want %h", k, out_onehot, exp_oh(mq[0])); end
        compared++; if (out_tag !== mq[0].tag) begin mismatched++; $display("FAIL rnd_tag cyc %0d got %0d want %0d", k, out_tag, mq[0].tag); end
      end
      compared++; if (out_count !== exp_cnt()) begin mismatched++; $display("FAIL rnd_count cyc %0d got %h want %h", k, out_count, exp_cnt()); end
    end
  endtask

  task automatic test_reset_mid();
    step(1, 3'd1, 1, 0);
    step(1, 3'd2, 1, 0);
    #2 rst = 1'b1;
    #1;
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_valid got %b want 0", out_valid); end
    compared++; if (in_ready !== 1'b0) begin mismatched++; $display("FAIL mid_ready got %b want 0", in_ready); end
    compared++; if (out_onehot !== '0 || out_count !== 16'h0) begin mismatched++; $display("FAIL mid_clear got %h/%h want 0/0", out_onehot, out_count); end
    mq.delete(); mcnt = 0;
    @(negedge clk);
    rst = 1'b0;
    step(1, 3'd6, 1, 1);
    compared++; if (out_valid !== 1'b1 || out_onehot !== 8'h40 || out_tag !== 3'd6) begin
      mismatched++; $display("FAIL mid_new got %b/%h/%0d want 1/40/6", out_valid, out_onehot, out_tag);
    end
    step(0, 3'd0, 0, 1);
    compared++; if (out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_noreplay got %b want 0", out_valid); end
  endtask

  task automatic test_stats();
`ifdef TAG_DECODER_STATS_EN
    for (int k = 0; k < 70000; k++) step(1, TW'($urandom), 1'($urandom), 1);
    compared++; if (out_count !== 16'hFFFF) begin mismatched++; $display("FAIL stats_sat got %h want FFFF", out_count); end
`else
    for (int k = 0; k < 300; k++) step(1, TW'($urandom), 1'($urandom), 1);
    compared++; if (out_count !== 16'h0000) begin mismatched++; $display("FAIL stats_off got %h want 0000", out_count); end
`endif
    compared++; if (out_count !== exp_cnt()) begin mismatched++; $display("FAIL stats_model got %h want %h", out_count, exp_cnt()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_skid();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
